// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, requester ids and
// the width of a captured request record.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic [1:0] {SRC_BOOT, SRC_CPU, SRC_VID} arb_src_t;

  // Record fields beyond the address: write flag, bank, data byte.
  localparam int REQ_META_W = 1 + 2 + 8;

  function automatic int req_w(input int aw);
    return aw + REQ_META_W;
  endfunction

endpackage

// File: rtl/arb_req_slot.sv
// One-entry request capture register: holds a pending request and its
// payload until the arbiter completes it; a second request while full is lost.
module arb_req_slot
  import sdram_arb_pkg::*;
#(
  parameter int W         = 8,
  parameter bit FLAG_DROP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         pend,
  output logic [W-1:0] data,
  output logic         drop
);

  logic accept;

  // A completion in the same cycle frees the slot before the new request is judged.
  assign accept = set & (~pend | clr);
  assign drop   = FLAG_DROP & set & pend & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      // NOTE: the payload is a plain register, so it is reset to keep downstream outputs at 0.
      data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pend <= accept | (pend & ~clr);
      if (accept) data <= din;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between the boot loader, the CPU and the
// video fetcher: one access in flight, video favoured, CPU starvation bounded.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW     = 23,
  parameter int RD_LAT = 5,
  parameter int STARVE = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          boot_mode,
  input  logic          boot_wr,
  input  logic [AW-1:0] boot_addr,
  input  logic [1:0]    boot_bank,
  input  logic [7:0]    boot_din,
  output logic          boot_full,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [1:0]    cpu_bank,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [15:0]   vid_dout,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_we,
  output logic [AW-1:0] cmd_addr,
  output logic [1:0]    cmd_bank,
  output logic [7:0]    cmd_din,
  input  logic [15:0]   rsp_data,
  output logic          ovf
);

  localparam int RW = req_w(AW);
  localparam int CW = $clog2(RD_LAT) + 1;
  localparam int SW = $clog2(STARVE + 1) + 1;

  arb_state_t    state, state_nxt;
  arb_src_t      src, grant_src;
  logic          grant;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;

  logic          cpu_lvl_q, cpu_edge, cpu_busy, byp, byp_ack;
  logic          cpu_set, cpu_clr, done_boot, done_cpu, done_vid, rd_last;
  logic          boot_pend, cpu_pend, vid_pend;
  logic          boot_drop, cpu_drop, vid_drop;
  logic [RW-1:0] boot_q, cpu_q;
  logic [AW-1:0] vid_q;

  logic          boot_we_q, cpu_we_q;
  logic [1:0]    boot_bank_q, cpu_bank_q;
  logic [7:0]    boot_din_q, cpu_din_q;
  logic [AW-1:0] boot_addr_q, cpu_addr_q;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [1:0]    sel_bank;
  logic [7:0]    sel_din;

  assign cpu_edge  = (cpu_rd | cpu_wr) & ~cpu_lvl_q;
  assign cpu_busy  = (state != IDLE) && (src == SRC_CPU);
  assign done_boot = (state == DONE) && (src == SRC_BOOT);
  assign done_cpu  = (state == DONE) && (src == SRC_CPU);
  assign done_vid  = (state == DONE) && (src == SRC_VID);
  assign rd_last   = (state == WAIT) && (cnt == '0);

  // Boot mode answers the CPU locally; a fresh edge is served without occupying the slot.
  assign byp     = boot_mode & ~cpu_busy & (cpu_pend | cpu_edge);
  assign cpu_set = cpu_edge & ~(byp & ~cpu_pend);
  assign cpu_clr = done_cpu | (byp & cpu_pend);

  arb_req_slot #(.W(RW), .FLAG_DROP(1'b1)) u_boot_slot (
    .clk(clk_sys), .rst(reset), .set(boot_wr), .clr(done_boot),
    .din({1'b1, boot_bank, boot_din, boot_addr}),
    .pend(boot_pend), .data(boot_q), .drop(boot_drop)
  );

  arb_req_slot #(.W(RW), .FLAG_DROP(1'b1)) u_cpu_slot (
    .clk(clk_sys), .rst(reset), .set(cpu_set), .clr(cpu_clr),
    .din({cpu_wr, cpu_bank, cpu_din, cpu_addr}),
    .pend(cpu_pend), .data(cpu_q), .drop(cpu_drop)
  );

  // A lost video fetch is harmless: the next scan line fetches again.
  arb_req_slot #(.W(AW), .FLAG_DROP(1'b0)) u_vid_slot (
    .clk(clk_sys), .rst(reset), .set(vid_req), .clr(done_vid),
    .din(vid_addr & ~AW'(1)),
    .pend(vid_pend), .data(vid_q), .drop(vid_drop)
  );

  assign {boot_we_q, boot_bank_q, boot_din_q, boot_addr_q} = boot_q;
  assign {cpu_we_q, cpu_bank_q, cpu_din_q, cpu_addr_q}     = cpu_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_nxt = state;
    grant     = 1'b0;
    grant_src = SRC_VID;
    case (state)
      IDLE: begin
        if (boot_mode) begin
          if (boot_pend)     begin grant = 1'b1; grant_src = SRC_BOOT; end
          else if (vid_pend) begin grant = 1'b1; grant_src = SRC_VID;  end
        end else if (cpu_pend && starve == SW'(STARVE)) begin
          grant = 1'b1; grant_src = SRC_CPU;
        end else if (vid_pend)  begin grant = 1'b1; grant_src = SRC_VID;  end
        else if (cpu_pend)      begin grant = 1'b1; grant_src = SRC_CPU;  end
        else if (boot_pend)     begin grant = 1'b1; grant_src = SRC_BOOT; end
        if (grant) state_nxt = ISSUE;
      end
      ISSUE:   if (cmd_ready) state_nxt = sel_we ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_bank = '0;
    sel_din  = '0;
    case (src)
      SRC_BOOT: begin
        sel_we = boot_we_q; sel_addr = boot_addr_q; sel_bank = boot_bank_q; sel_din = boot_din_q;
      end
      SRC_CPU: begin
        sel_we = cpu_we_q; sel_addr = cpu_addr_q; sel_bank = cpu_bank_q; sel_din = cpu_din_q;
      end
      SRC_VID: sel_addr = vid_q;
      default: sel_addr = '0;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src       <= SRC_BOOT;
      cnt       <= '0;
      starve    <= '0;
      cpu_lvl_q <= 1'b0;
      byp_ack   <= 1'b0;
      cpu_dout  <= '0;
      vid_dout  <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_lvl_q <= cpu_rd | cpu_wr;
      byp_ack   <= byp;
      if (grant) src <= grant_src;

      if (state == ISSUE && cmd_ready) cnt <= CW'(RD_LAT - 1);
      else if (state == WAIT)          cnt <= cnt - CW'(1);

      if (byp)                             cpu_dout <= 8'hFF;
      else if (rd_last && src == SRC_CPU)  cpu_dout <= cpu_addr_q[0] ? rsp_data[15:8] : rsp_data[7:0];
      if (rd_last && src == SRC_VID)       vid_dout <= rsp_data;

      if (!cpu_pend || (grant && grant_src == SRC_CPU))
        starve <= '0;
      else if (grant && grant_src == SRC_VID && starve != SW'(STARVE))
        starve <= starve + SW'(1);

      ovf <= ovf | boot_drop | cpu_drop | vid_drop;
    end
  end

  assign cmd_valid = (state == ISSUE);
  assign cmd_we    = cmd_valid & sel_we;
  assign cmd_addr  = cmd_valid ? sel_addr : '0;
  assign cmd_bank  = cmd_valid ? sel_bank : '0;
  assign cmd_din   = cmd_valid ? sel_din  : '0;
  assign cpu_ack   = done_cpu | byp_ack;
  assign vid_ack   = done_vid;
  assign boot_full = boot_pend;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: controller model returns read data
// exactly RD_LAT cycles after accept, and every scenario checks hand-derived timing.
module tb_sdram_port_arbiter;

  localparam int AW     = 23;
  localparam int RD_LAT = 5;
  localparam int STARVE = 2;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          boot_mode, boot_wr;
  logic [AW-1:0] boot_addr;
  logic [1:0]    boot_bank;
  logic [7:0]    boot_din;
  logic          boot_full;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [1:0]    cpu_bank;
  logic [7:0]    cpu_din;
  logic          cpu_ack;
  logic [7:0]    cpu_dout;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [15:0]   vid_dout;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_bank;
  logic [7:0]    cmd_din;
  logic [15:0]   rsp_data;
  logic          ovf;

  int n_checks = 0;
  int n_pass   = 0;

  int            cyc, n_acc, n_cpu, n_vid, n_valid, last_acc, cpu_ack_cyc, vid_ack_cyc;
  logic          acc_we   [8];
  logic [AW-1:0] acc_addr [8];
  logic [1:0]    acc_bank [8];
  logic [7:0]    acc_din  [8];
  int            acc_cyc  [8];
  logic [7:0]    cpu_val;
  logic [15:0]   vid_val;
  logic [15:0]   rsp_word;
  logic [62:0]   outs;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
    .clk_sys(clk_sys), .reset(reset), .boot_mode(boot_mode),
    .boot_wr(boot_wr), .boot_addr(boot_addr), .boot_bank(boot_bank), .boot_din(boot_din),
    .boot_full(boot_full),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_bank(cmd_bank), .cmd_din(cmd_din), .rsp_data(rsp_data), .ovf(ovf)
  );

  task automatic clear_log();
    cyc = 0; n_acc = 0; n_cpu = 0; n_vid = 0; n_valid = 0;
    last_acc = -100; cpu_ack_cyc = -1; vid_ack_cyc = -1;
  endtask

  // Runs a fixed number of cycles, sampling on the falling edge, logging accepted
  // commands and acks, and playing the controller that returns data RD_LAT later.
  task automatic observe(input int cycles, input int vid_rereq);
    int rr = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_sys);
      vid_req = 1'b0;
      cyc++;
      if (cmd_valid) n_valid++;
      if (cmd_valid && cmd_ready) begin
        if (n_acc < 8) begin
          acc_we[n_acc] = cmd_we; acc_addr[n_acc] = cmd_addr;
          acc_bank[n_acc] = cmd_bank; acc_din[n_acc] = cmd_din; acc_cyc[n_acc] = cyc;
        end
        n_acc++;
        last_acc = cyc;
      end
      rsp_data = (cyc == last_acc + RD_LAT) ? rsp_word : 16'h0F0F;
      if (vid_ack) begin
        if (n_vid == 0) vid_ack_cyc = cyc;
        vid_val = vid_dout;
        n_vid++;
        if (rr < vid_rereq) begin vid_req = 1'b1; rr++; end
      end
      if (cpu_ack) begin
        if (n_cpu == 0) cpu_ack_cyc = cyc;
        cpu_val = cpu_dout;
        n_cpu++;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    outs = {cmd_valid, cmd_we, cmd_addr, cmd_bank, cmd_din, cpu_ack, cpu_dout,
            vid_ack, vid_dout, boot_full, ovf};
    n_checks++; if (outs !== 63'h0) $display("FAIL reset_outputs: got %h, expected 0", outs); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL idle_cmd_valid: got %b, expected 0", cmd_valid); else n_pass++;
  endtask

  task automatic test_cpu_read();
    cpu_rd = 1'b1; cpu_addr = 23'h000123; cpu_bank = 2'd0; rsp_word = 16'hA55A;
    clear_log();
    observe(15, 0);
    n_checks++; if (n_acc !== 1) $display("FAIL rd_cmd_count: got %0d, expected 1", n_acc); else n_pass++;
    n_checks++; if (acc_we[0] !== 1'b0) $display("FAIL rd_cmd_we: got %b, expected 0", acc_we[0]); else n_pass++;
    n_checks++; if (acc_addr[0] !== 23'h000123) $display("FAIL rd_cmd_addr: got %h, expected 000123", acc_addr[0]); else n_pass++;
    n_checks++; if (acc_cyc[0] !== 2) $display("FAIL rd_issue_cycle: got %0d, expected 2", acc_cyc[0]); else n_pass++;
    n_checks++; if (cpu_ack_cyc !== RD_LAT + 3) $display("FAIL rd_ack_latency: got %0d, expected %0d", cpu_ack_cyc, RD_LAT + 3); else n_pass++;
    n_checks++; if (n_cpu !== 1) $display("FAIL rd_ack_pulses: got %0d, expected 1", n_cpu); else n_pass++;
    n_checks++; if (cpu_val !== 8'hA5) $display("FAIL rd_data_hi: got %h, expected a5", cpu_val); else n_pass++;
    n_checks++; if (cpu_dout !== 8'hA5) $display("FAIL rd_data_held: got %h, expected a5", cpu_dout); else n_pass++;
  endtask

  task automatic test_vid_and_cpu_write();
    @(negedge clk_sys);
    vid_req = 1'b1; vid_addr = 23'h000401;
    cpu_wr = 1'b1; cpu_addr = 23'h000200; cpu_bank = 2'd2; cpu_din = 8'h5C;
    rsp_word = 16'hBEEF;
    clear_log();
    observe(30, 0);
    n_checks++; if (n_acc !== 2) $display("FAIL vw_cmd_count: got %0d, expected 2", n_acc); else n_pass++;
    n_checks++; if ({acc_we[0], acc_addr[0]} !== {1'b0, 23'h000400}) $display("FAIL vw_first_is_video: got %b/%h, expected 0/000400", acc_we[0], acc_addr[0]); else n_pass++;
    n_checks++; if (vid_ack_cyc !== 8) $display("FAIL vw_vid_ack_cycle: got %0d, expected 8", vid_ack_cyc); else n_pass++;
    n_checks++; if (vid_val !== 16'hBEEF) $display("FAIL vw_vid_data: got %h, expected beef", vid_val); else n_pass++;
    n_checks++; if ({acc_we[1], acc_addr[1], acc_bank[1], acc_din[1]} !== {1'b1, 23'h000200, 2'd2, 8'h5C})
      $display("FAIL vw_cpu_write_cmd: got %b/%h/%0d/%h, expected 1/000200/2/5c", acc_we[1], acc_addr[1], acc_bank[1], acc_din[1]);
    else n_pass++;
    n_checks++; if (cpu_ack_cyc !== 11) $display("FAIL vw_cpu_ack_cycle: got %0d, expected 11", cpu_ack_cyc); else n_pass++;
    n_checks++; if (n_cpu !== 1) $display("FAIL vw_cpu_ack_pulses: got %0d, expected 1", n_cpu); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL vw_ovf: got %b, expected 0", ovf); else n_pass++;
  endtask

  task automatic test_starvation();
    @(negedge clk_sys);
    vid_req = 1'b1; vid_addr = 23'h000400;
    cpu_rd = 1'b1; cpu_addr = 23'h000777; rsp_word = 16'h1234;
    clear_log();
    observe(60, 2);
    n_checks++; if (n_acc !== 4) $display("FAIL sv_cmd_count: got %0d, expected 4", n_acc); else n_pass++;
    n_checks++; if ({acc_addr[0], acc_addr[1]} !== {23'h000400, 23'h000400}) $display("FAIL sv_two_video_first: got %h %h, expected 000400 000400", acc_addr[0], acc_addr[1]); else n_pass++;
    n_checks++; if (acc_addr[2] !== 23'h000777) $display("FAIL sv_cpu_third: got %h, expected 000777", acc_addr[2]); else n_pass++;
    n_checks++; if (acc_addr[3] !== 23'h000400) $display("FAIL sv_video_after_cpu: got %h, expected 000400", acc_addr[3]); else n_pass++;
    n_checks++; if (cpu_ack_cyc !== (STARVE + 1) * (RD_LAT + 3)) $display("FAIL sv_cpu_worst_latency: got %0d, expected %0d", cpu_ack_cyc, (STARVE + 1) * (RD_LAT + 3)); else n_pass++;
    n_checks++; if (cpu_val !== 8'h12) $display("FAIL sv_cpu_data: got %h, expected 12", cpu_val); else n_pass++;
    n_checks++; if (n_vid !== 3) $display("FAIL sv_video_acks: got %0d, expected 3", n_vid); else n_pass++;
  endtask

  task automatic test_boot_bypass();
    @(negedge clk_sys);
    boot_mode = 1'b1;
    @(negedge clk_sys);
    cpu_rd = 1'b1; cpu_addr = 23'h000055;
    clear_log();
    observe(10, 0);
    n_checks++; if (cpu_ack_cyc !== 1) $display("FAIL bp_ack_cycle: got %0d, expected 1", cpu_ack_cyc); else n_pass++;
    n_checks++; if (n_cpu !== 1) $display("FAIL bp_ack_pulses: got %0d, expected 1", n_cpu); else n_pass++;
    n_checks++; if (cpu_val !== 8'hFF) $display("FAIL bp_data: got %h, expected ff", cpu_val); else n_pass++;
    n_checks++; if (n_valid !== 0) $display("FAIL bp_no_sdram_cycle: got %0d cmd cycles, expected 0", n_valid); else n_pass++;
  endtask

  task automatic test_boot_overflow();
    @(negedge clk_sys);
    cmd_ready = 1'b0;
    boot_wr = 1'b1; boot_addr = 23'h001000; boot_bank = 2'd1; boot_din = 8'h11;
    @(negedge clk_sys);
    boot_wr = 1'b0;
    n_checks++; if ({boot_full, ovf} !== 2'b10) $display("FAIL bo_first_full_ovf: got %b, expected 10", {boot_full, ovf}); else n_pass++;
    @(negedge clk_sys);
    boot_wr = 1'b1; boot_addr = 23'h002000; boot_din = 8'h22;
    @(negedge clk_sys);
    boot_wr = 1'b0;
    n_checks++; if ({boot_full, ovf} !== 2'b11) $display("FAIL bo_second_full_ovf: got %b, expected 11", {boot_full, ovf}); else n_pass++;
    n_checks++; if ({cmd_valid, cmd_we, cmd_addr, cmd_bank, cmd_din} !== {1'b1, 1'b1, 23'h001000, 2'd1, 8'h11})
      $display("FAIL bo_cmd_holds_first: got %b/%b/%h/%0d/%h, expected 1/1/001000/1/11", cmd_valid, cmd_we, cmd_addr, cmd_bank, cmd_din);
    else n_pass++;
    cmd_ready = 1'b1;
    clear_log();
    observe(6, 0);
    n_checks++; if (n_valid !== 0) $display("FAIL bo_dropped_not_issued: got %0d cmd cycles, expected 0", n_valid); else n_pass++;
    n_checks++; if ({boot_full, ovf} !== 2'b01) $display("FAIL bo_drain_sticky_ovf: got %b, expected 01", {boot_full, ovf}); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk_sys);
    boot_mode = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 23'h000124; rsp_word = 16'hA55A;
    clear_log();
    observe(4, 0);
    reset = 1'b1;
    #1;
    outs = {cmd_valid, cmd_we, cmd_addr, cmd_bank, cmd_din, cpu_ack, cpu_dout,
            vid_ack, vid_dout, boot_full, ovf};
    n_checks++; if (outs !== 63'h0) $display("FAIL rm_outputs_zero: got %h, expected 0", outs); else n_pass++;
    cpu_rd = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    clear_log();
    observe(12, 0);
    n_checks++; if ({n_cpu, n_valid} !== {32'd0, 32'd0}) $display("FAIL rm_abandoned: got %0d acks %0d cmd cycles, expected 0 0", n_cpu, n_valid); else n_pass++;
    cpu_rd = 1'b1; rsp_word = 16'h3C7E;
    clear_log();
    observe(15, 0);
    n_checks++; if (cpu_ack_cyc !== RD_LAT + 3) $display("FAIL rm_next_latency: got %0d, expected %0d", cpu_ack_cyc, RD_LAT + 3); else n_pass++;
    n_checks++; if (cpu_val !== 8'h7E) $display("FAIL rm_next_data_lo: got %h, expected 7e", cpu_val); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; boot_mode = 1'b0; boot_wr = 1'b0; boot_addr = '0; boot_bank = '0; boot_din = '0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_bank = '0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0; cmd_ready = 1'b1; rsp_data = '0; rsp_word = '0;
    cpu_val = '0; vid_val = '0;
    clear_log();
    test_reset();
    test_cpu_read();
    test_vid_and_cpu_write();
    test_starvation();
    test_boot_bypass();
    test_boot_overflow();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
